// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle ARM-subset control path: FSM states, ALU ops,
// condition codes, data-processing commands and NZCV bit positions.
package cpu_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMRD    = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWR    = 4'd5;
    localparam logic [3:0] ST_EXECUTER = 4'd6;
    localparam logic [3:0] ST_EXECUTEI = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;

    typedef enum logic [3:0] {
        FETCH    = ST_FETCH,
        DECODE   = ST_DECODE,
        MEMADR   = ST_MEMADR,
        MEMRD    = ST_MEMRD,
        MEMWB    = ST_MEMWB,
        MEMWR    = ST_MEMWR,
        EXECUTER = ST_EXECUTER,
        EXECUTEI = ST_EXECUTEI,
        ALUWB    = ST_ALUWB,
        BRANCH   = ST_BRANCH
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/mc_controller_if.sv
// Instruction fields and ALU flags into the controller, datapath controls out of it.
// master = controller side, slave = datapath side.
interface mc_controller_if;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [2:0] ALUControl;

    modport master (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
    );

    modport slave (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
    );
endinterface

// File: rtl/cond_check.sv
// ARM condition-code evaluation against the registered NZCV flags.
// Code 1111 is treated as never-execute.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_cond_ex
);
    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = ~w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = ~w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = ~w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = ~w_v;
            COND_HI: o_cond_ex = w_c & ~w_z;
            COND_LS: o_cond_ex = ~w_c | w_z;
            COND_GE: o_cond_ex = (w_n == w_v);
            COND_LT: o_cond_ex = (w_n != w_v);
            COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
            COND_LE: o_cond_ex = w_z | (w_n != w_v);
            COND_AL: o_cond_ex = 1'b1;
            default: o_cond_ex = 1'b0;
        endcase
    end
endmodule

// File: rtl/mc_controller.sv
// Multicycle Moore control unit: instruction sequencing FSM, ALU decode, NZCV register
// and condition gating of every architectural write.
module mc_controller
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    mc_controller_if.master     bus,
    output state_t              o_state,
    output logic [3:0]          o_flags,
    output logic                o_cond_ex
);
    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] w_dec_state;
    logic [3:0] r_flags;
    logic       r_cond_ex;
    logic       w_cond_ex;

    logic       w_i, w_s, w_u, w_l;
    logic [3:0] w_cmd;
    logic [2:0] w_alu_ctrl;
    logic       w_nowrite, w_legal, w_arith, w_rd_pc;

    logic       w_pc_write, w_mem_write, w_reg_write, w_ir_write, w_adr_src, w_alu_src_a;
    logic [1:0] w_alu_src_b, w_result_src, w_imm_src, w_reg_src;
    logic [2:0] w_alu_control;

    assign w_i     = bus.Funct[5];
    assign w_cmd   = bus.Funct[4:1];
    assign w_s     = bus.Funct[0];
    assign w_u     = bus.Funct[3];
    assign w_l     = bus.Funct[0];
    assign w_rd_pc = (bus.Rd == 4'd15);

    cond_check u_cond_check (
        .i_cond    (bus.Cond),
        .i_flags   (r_flags),
        .o_cond_ex (w_cond_ex)
    );

    always_comb begin
        w_alu_ctrl = ALU_ADD;
        w_nowrite  = 1'b1;
        w_legal    = 1'b0;
        w_arith    = 1'b0;
        case (w_cmd)
            CMD_ADD: begin w_alu_ctrl = ALU_ADD; w_nowrite = 1'b0; w_legal = 1'b1; w_arith = 1'b1; end
            CMD_SUB: begin w_alu_ctrl = ALU_SUB; w_nowrite = 1'b0; w_legal = 1'b1; w_arith = 1'b1; end
            CMD_AND: begin w_alu_ctrl = ALU_AND; w_nowrite = 1'b0; w_legal = 1'b1; end
            CMD_ORR: begin w_alu_ctrl = ALU_OR;  w_nowrite = 1'b0; w_legal = 1'b1; end
            CMD_CMP: begin w_alu_ctrl = ALU_SUB; w_legal = 1'b1; w_arith = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        w_next = ST_FETCH;
        case (r_state)
            ST_FETCH:  w_next = ST_DECODE;
            ST_DECODE: begin
                case (bus.Op)
                    2'b00:   w_next = w_i ? ST_EXECUTEI : ST_EXECUTER;
                    2'b01:   w_next = ST_MEMADR;
                    2'b10:   w_next = ST_BRANCH;
                    default: w_next = ST_FETCH;
                endcase
            end
            ST_MEMADR:   w_next = w_l ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:    w_next = ST_MEMWB;
            ST_EXECUTER: w_next = ST_ALUWB;
            ST_EXECUTEI: w_next = ST_ALUWB;
            default:     w_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_flags   <= 4'b0000;
            r_cond_ex <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE)
                r_cond_ex <= w_cond_ex;
            // Logical ops leave C and V alone; unknown commands touch nothing.
            if ((r_state == ST_EXECUTER || r_state == ST_EXECUTEI) && w_s && r_cond_ex && w_legal) begin
                r_flags[3:2] <= bus.ALUFlags[3:2];
                if (w_arith)
                    r_flags[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end

    // During reset the decode shows FETCH muxing; the enables are masked below.
    assign w_dec_state = reset ? ST_FETCH : r_state;

    always_comb begin
        w_pc_write    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_ir_write    = 1'b0;
        w_adr_src     = 1'b0;
        w_alu_src_a   = 1'b0;
        w_alu_src_b   = 2'b00;
        w_result_src  = 2'b00;
        w_imm_src     = 2'b00;
        w_reg_src     = 2'b00;
        w_alu_control = ALU_ADD;
        case (w_dec_state)
            ST_FETCH: begin
                w_ir_write   = 1'b1;
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_pc_write   = 1'b1;
            end
            ST_DECODE: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            ST_MEMADR: begin
                w_alu_src_b   = 2'b01;
                w_imm_src     = 2'b01;
                w_alu_control = w_u ? ALU_ADD : ALU_SUB;
                w_reg_src     = {~w_l, 1'b0};
            end
            ST_MEMRD: w_adr_src = 1'b1;
            ST_MEMWR: begin
                w_adr_src   = 1'b1;
                w_mem_write = r_cond_ex;
                w_reg_src   = 2'b10;
            end
            ST_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = r_cond_ex;
            end
            ST_EXECUTER: w_alu_control = w_alu_ctrl;
            ST_EXECUTEI: begin
                w_alu_src_b   = 2'b01;
                w_alu_control = w_alu_ctrl;
            end
            ST_ALUWB: begin
                w_reg_write = r_cond_ex & ~w_nowrite & ~w_rd_pc;
                w_pc_write  = r_cond_ex & ~w_nowrite & w_rd_pc;
            end
            ST_BRANCH: begin
                w_alu_src_b  = 2'b01;
                w_imm_src    = 2'b10;
                w_reg_src    = 2'b01;
                w_result_src = 2'b10;
                w_pc_write   = r_cond_ex;
            end
            default: ;
        endcase
    end

    assign bus.PCWrite    = w_pc_write  & ~reset;
    assign bus.MemWrite   = w_mem_write & ~reset;
    assign bus.RegWrite   = w_reg_write & ~reset;
    assign bus.IRWrite    = w_ir_write  & ~reset;
    assign bus.AdrSrc     = w_adr_src;
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.ResultSrc  = w_result_src;
    assign bus.ImmSrc     = w_imm_src;
    assign bus.RegSrc     = w_reg_src;
    assign bus.ALUControl = w_alu_control;

    assign o_state   = state_t'(r_state);
    assign o_flags   = r_flags;
    assign o_cond_ex = r_cond_ex;
endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks hand-written instructions through the FSM
// and checks state, controls and flags against hand-computed values.
module tb_mc_controller;
    import cpu_pkg::*;

    logic       clk;
    logic       reset;
    state_t     o_state;
    logic [3:0] o_flags;
    logic       o_cond_ex;
    int         n_pass;
    int         n_total;

    mc_controller_if bus ();

    mc_controller dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .o_state   (o_state),
        .o_flags   (o_flags),
        .o_cond_ex (o_cond_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                             input logic [3:0] rd, input logic [3:0] af);
        bus.Cond     = c;
        bus.Op       = op;
        bus.Funct    = f;
        bus.Rd       = rd;
        bus.ALUFlags = af;
    endtask

    task automatic chk_state(input string tag, input logic [3:0] exp);
        check(tag, 32'(o_state), 32'(exp));
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        set_instr(4'b1110, 2'b00, 6'b001000, 4'd1, 4'b0000);

        // reset: enables masked, mux outputs at FETCH values
        tick();
        check("rst_pcwrite", 32'(bus.PCWrite), 32'd0);
        check("rst_irwrite", 32'(bus.IRWrite), 32'd0);
        check("rst_srcb", 32'(bus.ALUSrcB), 32'b10);
        tick();
        chk_state("rst_state", ST_FETCH);
        check("rst_flags", 32'(o_flags), 32'd0);
        reset = 1'b0;
        #1;
        check("rel_pcwrite", 32'(bus.PCWrite), 32'd1);
        check("rel_irwrite", 32'(bus.IRWrite), 32'd1);
        check("rel_ressrc", 32'(bus.ResultSrc), 32'b10);

        // ADD R1,R2,R3
        tick(); chk_state("add_decode", ST_DECODE);
        check("add_dec_srca", 32'(bus.ALUSrcA), 32'd1);
        tick(); chk_state("add_exer", ST_EXECUTER);
        check("add_aluctl", 32'(bus.ALUControl), 32'b000);
        check("add_srcb", 32'(bus.ALUSrcB), 32'b00);
        tick(); chk_state("add_aluwb", ST_ALUWB);
        check("add_regwrite", 32'(bus.RegWrite), 32'd1);
        check("add_pcwrite", 32'(bus.PCWrite), 32'd0);
        tick(); chk_state("add_fetch", ST_FETCH);

        // CMPS R1,R2 with ALU reporting Z
        set_instr(4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0100);
        tick(); tick();
        check("cmp_aluctl", 32'(bus.ALUControl), 32'b001);
        tick(); chk_state("cmp_aluwb", ST_ALUWB);
        check("cmp_flags", 32'(o_flags), 32'b0100);
        check("cmp_regwrite", 32'(bus.RegWrite), 32'd0);
        check("cmp_pcwrite", 32'(bus.PCWrite), 32'd0);
        tick();

        // BEQ taken (Z=1)
        set_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000);
        tick(); tick(); chk_state("beq_branch", ST_BRANCH);
        check("beq_pcwrite", 32'(bus.PCWrite), 32'd1);
        check("beq_immsrc", 32'(bus.ImmSrc), 32'b10);
        check("beq_regsrc", 32'(bus.RegSrc), 32'b01);
        check("beq_srcb", 32'(bus.ALUSrcB), 32'b01);
        tick(); chk_state("beq_fetch", ST_FETCH);

        // BNE not taken (Z=1)
        set_instr(4'b0001, 2'b10, 6'b100000, 4'd0, 4'b0000);
        tick(); tick(); chk_state("bne_branch", ST_BRANCH);
        check("bne_pcwrite", 32'(bus.PCWrite), 32'd0);
        check("bne_condex", 32'(o_cond_ex), 32'd0);
        tick(); chk_state("bne_fetch", ST_FETCH);

        // LDR, U=0
        set_instr(4'b1110, 2'b01, 6'b010001, 4'd3, 4'b0000);
        tick(); tick(); chk_state("ldr_memadr", ST_MEMADR);
        check("ldr_aluctl", 32'(bus.ALUControl), 32'b001);
        check("ldr_immsrc", 32'(bus.ImmSrc), 32'b01);
        check("ldr_srca", 32'(bus.ALUSrcA), 32'd0);
        tick(); chk_state("ldr_memrd", ST_MEMRD);
        check("ldr_adrsrc", 32'(bus.AdrSrc), 32'd1);
        check("ldr_memwrite", 32'(bus.MemWrite), 32'd0);
        tick(); chk_state("ldr_memwb", ST_MEMWB);
        check("ldr_regwrite", 32'(bus.RegWrite), 32'd1);
        check("ldr_ressrc", 32'(bus.ResultSrc), 32'b01);
        tick(); chk_state("ldr_fetch", ST_FETCH);

        // SUB R15,...: result goes to PC
        set_instr(4'b1110, 2'b00, 6'b000100, 4'd15, 4'b0000);
        tick(); tick();
        check("sub_aluctl", 32'(bus.ALUControl), 32'b001);
        tick();
        check("sub15_pcwrite", 32'(bus.PCWrite), 32'd1);
        check("sub15_regwrite", 32'(bus.RegWrite), 32'd0);
        tick();

        // ORR immediate
        set_instr(4'b1110, 2'b00, 6'b111000, 4'd2, 4'b0000);
        tick(); tick(); chk_state("orr_exei", ST_EXECUTEI);
        check("orr_aluctl", 32'(bus.ALUControl), 32'b011);
        check("orr_srcb", 32'(bus.ALUSrcB), 32'b01);
        check("orr_immsrc", 32'(bus.ImmSrc), 32'b00);
        tick(); tick();

        // CMPS setting C,V, then ANDS updates only N,Z
        set_instr(4'b1110, 2'b00, 6'b010101, 4'd0, 4'b0011);
        tick(); tick(); tick();
        check("cmp2_flags", 32'(o_flags), 32'b0011);
        tick();
        set_instr(4'b1110, 2'b00, 6'b000001, 4'd4, 4'b1000);
        tick(); tick(); tick();
        check("ands_flags", 32'(o_flags), 32'b1011);
        check("ands_regwrite", 32'(bus.RegWrite), 32'd1);
        tick();

        // Cond=1111 never executes
        set_instr(4'b1111, 2'b00, 6'b001000, 4'd1, 4'b0000);
        tick(); tick(); tick();
        check("nv_regwrite", 32'(bus.RegWrite), 32'd0);
        tick();

        // Op=11 returns straight to FETCH
        set_instr(4'b1110, 2'b11, 6'b000000, 4'd1, 4'b0000);
        tick(); tick(); chk_state("illegal_fetch", ST_FETCH);

        // STR, aborted by reset while in MEMWR
        set_instr(4'b1110, 2'b01, 6'b011000, 4'd5, 4'b0000);
        tick(); tick();
        check("str_aluctl", 32'(bus.ALUControl), 32'b000);
        tick(); chk_state("str_memwr", ST_MEMWR);
        check("str_memwrite", 32'(bus.MemWrite), 32'd1);
        check("str_adrsrc", 32'(bus.AdrSrc), 32'd1);
        reset = 1'b1;
        #1;
        check("str_rst_memwrite", 32'(bus.MemWrite), 32'd0);
        check("str_rst_pcwrite", 32'(bus.PCWrite), 32'd0);
        tick();
        chk_state("str_rst_state", ST_FETCH);
        check("str_rst_flags", 32'(o_flags), 32'd0);
        check("str_rst_condex", 32'(o_cond_ex), 32'd0);
        reset = 1'b0;
        #1;
        check("str_rel_pcwrite", 32'(bus.PCWrite), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
